// File: rtl/ariane_soc_pkg.sv
// SoC-wide constants and the bandwidth-regulator configuration bundle.
// Shared by the LLC bandwidth regulator and its per-core budget counters.
package ariane_soc;

  localparam int unsigned NumCores    = 4;
  localparam int unsigned BudgetWidth = 16;
  localparam int unsigned PeriodWidth = 32;
  localparam int unsigned LenWidth    = 8;

  typedef struct packed {
    logic                                en;
    logic [PeriodWidth-1:0]              period;
    logic [NumCores-1:0][BudgetWidth-1:0] budget;
  } bw_cfg_t;

endpackage

// File: rtl/bw_budget_counter.sv
// Per-core beat budget: replenish, deduct on accept, throttle and irq.
// Effective budget is the fresh budget in a replenish cycle.
module bw_budget_counter #(
  parameter int unsigned BudgetWidth = 16,
  parameter int unsigned LenWidth    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   replenish_i,
  input  logic [BudgetWidth-1:0] budget_i,
  input  logic                   valid_i,
  input  logic [LenWidth-1:0]    len_i,
  input  logic                   accept_i,
  output logic                   eligible_o,
  output logic                   throttled_o,
  output logic                   irq_o
);

  localparam int unsigned CmpW =
    ((BudgetWidth > LenWidth) ? BudgetWidth : LenWidth) + 1;

  logic [BudgetWidth-1:0] remaining_q;
  logic [BudgetWidth-1:0] effective;
  logic [CmpW-1:0]        beats;
  logic                   budget_ok;
  logic                   throttled_q;
  logic                   irq_q;

  assign effective   = replenish_i ? budget_i : remaining_q;
  assign beats       = CmpW'(len_i) + CmpW'(1);
  assign budget_ok   = CmpW'(effective) >= beats;
  assign eligible_o  = valid_i && (!en_i || budget_ok);
  assign throttled_o = en_i && valid_i && !budget_ok;
  assign irq_o       = irq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      remaining_q <= '0;
      throttled_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      throttled_q <= throttled_o;
      irq_q       <= throttled_o && !throttled_q;
      // Deduction already sees the replenished value when both coincide.
      if (en_i) begin
        if (accept_i) begin
          remaining_q <= effective - beats[BudgetWidth-1:0];
        end else if (replenish_i) begin
          remaining_q <= budget_i;
        end
      end
    end
  end

endmodule

// File: rtl/llc_bw_regulator.sv
// LLC bandwidth regulator: budget-gated round-robin over core requests.
// One registered grant slot toward the LLC, refillable back-to-back.
module llc_bw_regulator #(
  parameter int unsigned NumReq      = ariane_soc::NumCores,
  parameter int unsigned BudgetWidth = ariane_soc::BudgetWidth,
  parameter int unsigned PeriodWidth = ariane_soc::PeriodWidth,
  parameter int unsigned LenWidth    = ariane_soc::LenWidth,
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               cfg_en_i,
  input  logic [PeriodWidth-1:0]             cfg_period_i,
  input  logic [NumReq-1:0][BudgetWidth-1:0] cfg_budget_i,
  input  logic [NumReq-1:0]                  req_valid_i,
  input  logic [NumReq-1:0][LenWidth-1:0]    req_len_i,
  output logic [NumReq-1:0]                  req_ready_o,
  output logic                               mst_valid_o,
  input  logic                               mst_ready_i,
  output logic [IdxW-1:0]                    mst_idx_o,
  output logic [LenWidth-1:0]                mst_len_o,
  output logic [NumReq-1:0]                  throttled_o,
  output logic [NumReq-1:0]                  exhaust_irq_o
);

  logic [PeriodWidth-1:0] period_cnt_q;
  logic                   en_q;
  logic                   short_period;
  logic                   period_wrap;
  logic                   replenish;
  logic [NumReq-1:0]      eligible;
  logic [IdxW-1:0]        ptr_q;
  logic [IdxW-1:0]        win;
  logic [IdxW:0]          cand;
  logic                   found;
  logic                   load;
  logic                   grant;

  assign short_period = cfg_period_i <= PeriodWidth'(1);
  assign replenish    = (period_cnt_q == '0) || short_period;
  assign period_wrap  = short_period ||
                        (period_cnt_q >= cfg_period_i - PeriodWidth'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      period_cnt_q <= '0;
      en_q         <= 1'b0;
    end else begin
      en_q <= cfg_en_i;
      if ((cfg_en_i && !en_q) || period_wrap) begin
        period_cnt_q <= '0;
      end else begin
        period_cnt_q <= period_cnt_q + PeriodWidth'(1);
      end
    end
  end

  for (genvar g = 0; g < NumReq; g++) begin : g_budget
    bw_budget_counter #(
      .BudgetWidth (BudgetWidth),
      .LenWidth    (LenWidth)
    ) u_cnt (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .en_i        (cfg_en_i),
      .replenish_i (replenish),
      .budget_i    (cfg_budget_i[g]),
      .valid_i     (req_valid_i[g]),
      .len_i       (req_len_i[g]),
      .accept_i    (req_ready_o[g]),
      .eligible_o  (eligible[g]),
      .throttled_o (throttled_o[g]),
      .irq_o       (exhaust_irq_o[g])
    );
  end

  // Search starts one past the last winner and wraps at NumReq-1.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = {1'b0, ptr_q} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(NumReq)) begin
        cand = cand - (IdxW+1)'(NumReq);
      end
      if (!found && eligible[cand[IdxW-1:0]]) begin
        found = 1'b1;
        win   = cand[IdxW-1:0];
      end
    end
  end

  assign load  = !mst_valid_o || mst_ready_i;
  assign grant = load && found;

  always_comb begin
    req_ready_o = '0;
    if (grant) begin
      req_ready_o[win] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mst_valid_o <= 1'b0;
      mst_idx_o   <= '0;
      mst_len_o   <= '0;
      ptr_q       <= IdxW'(NumReq - 1);
    end else if (grant) begin
      mst_valid_o <= 1'b1;
      mst_idx_o   <= win;
      mst_len_o   <= req_len_i[win];
      ptr_q       <= win;
    end else if (mst_ready_i) begin
      mst_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/llc_bw_regulator.md
LLC_BW_REGULATOR -- requirements
Module: llc_bw_regulator

Interface
REQ-001 Parameter NumReq, default ariane_soc::NumCores (4), number of requesting cores.
REQ-002 Parameter BudgetWidth, default 16, width of per-period beat budget.
REQ-003 Parameter PeriodWidth, default 32, width of period counter.
REQ-004 Parameter LenWidth, default 8, AXI burst length field width.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 cfg_en_i  in  1  1 = budget regulation active, 0 = plain round-robin.
REQ-008 cfg_period_i  in  PeriodWidth  replenish period in cycles.
REQ-009 cfg_budget_i  in  NumReq x BudgetWidth  beats allowed per core per period.
REQ-010 req_valid_i  in  NumReq  core request pending.
REQ-011 req_len_i  in  NumReq x LenWidth  AXI len of request (beats = len+1).
REQ-012 req_ready_o  out  NumReq  request accepted this cycle.
REQ-013 mst_valid_o / mst_ready_i  out/in  1  downstream (LLC) handshake.
REQ-014 mst_idx_o  out  clog2(NumReq)  granted core; mst_len_o  out  LenWidth  granted len.
REQ-015 throttled_o  out  NumReq  core blocked by budget; exhaust_irq_o  out  NumReq  one-cycle pulse.

Function
REQ-016 Period counter SHALL count 0..cfg_period_i-1 and wrap to 0; cycle with counter==0 is a replenish cycle; cfg_period_i of 0 or 1 SHALL replenish every cycle.
REQ-017 In a replenish cycle each remaining budget SHALL load cfg_budget_i; effective budget that cycle = cfg_budget_i, else = remaining.
REQ-018 Core i eligible SHALL be req_valid_i[i] && (!cfg_en_i || effective[i] >= req_len_i[i]+1), compared at BudgetWidth+1 bits.
REQ-019 Arbitration SHALL be round-robin over eligible cores, search starting at last granted index +1, wrapping at NumReq-1.
REQ-020 Output register SHALL be loadable when empty or when mst_valid_o && mst_ready_i in the same cycle (back-to-back, one grant per cycle sustained).
REQ-021 On load: req_ready_o[winner]=1 that cycle (combinational, single bit set), mst_valid_o/idx/len registered next cycle (latency 1).
REQ-022 mst_valid_o, mst_idx_o, mst_len_o SHALL stay stable until mst_ready_i; no revocation.
REQ-023 On accept with cfg_en_i=1, remaining[winner] SHALL become effective[winner]-(len+1); replenish and deduction in same cycle compose (new budget minus beats).
REQ-024 Budget 0 with cfg_en_i=1 SHALL block that core permanently; cfg_en_i=0 SHALL leave remaining unchanged.
REQ-025 cfg_en_i rising edge SHALL reset period counter to 0 (next cycle is replenish).
REQ-026 throttled_o[i] = cfg_en_i && req_valid_i[i] && !eligible budget check; exhaust_irq_o[i] SHALL pulse on throttled_o[i] rising edge.
REQ-027 Changes to cfg_budget_i SHALL take effect only at next replenish; cfg_period_i changes take effect at next compare.

Reset
REQ-028 Reset SHALL set mst_valid_o=0, mst_idx_o=0, mst_len_o=0, req_ready_o=0, throttled/irq registers 0, remaining=0, counter=0, RR pointer so core 0 wins first.
REQ-029 Reset mid-transaction SHALL discard held grant; first cycle after release is a replenish cycle.

Structure
REQ-030 BudgetWidth/PeriodWidth constants and a bw_cfg_t struct (en, period, budget array) SHALL live in ariane_soc package.
REQ-031 Per-core budget logic SHALL be sub-module bw_budget_counter, instantiated NumReq times; arbiter and period counter in top.

Verification
REQ-032 en=0, all 4 valid len=0, ready=1 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-033 en=1, period=100, budget[0]=16, core0 len=7 continuous -> two grants, then throttled_o[0]=1, irq pulse once, next grant at replenish cycle.
REQ-034 ready=0 for 5 cycles with grant held -> mst_valid/idx/len stable, no req_ready_o asserted.
REQ-035 budget[2]=0, en=1, core2 valid -> never granted; other cores unaffected.
REQ-036 Accept in replenish cycle, budget=10, len=3 -> remaining=6.
REQ-037 rst_ni low while mst_valid_o=1 -> mst_valid_o=0 asynchronously; after release core 0 granted first.
